data_memory: RTL and testbench



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_load_align.sv | 27 ++
 rtl/data_memory.sv | 91 +++++++++
 tb/tb_data_memory.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the MEM-stage data memory: transfer size encodings
// and default geometry.
package dmem_pkg;

    localparam int DMEM_DEPTH = 512;
    localparam int DMEM_AW    = 9;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Number of bytes touched by a transfer; 0 for the reserved encoding.
    function automatic int unsigned size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 1;
            SZ_HALF: size_bytes = 2;
            SZ_WORD: size_bytes = 4;
            default: size_bytes = 0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load aligner: turns four big-endian fetched bytes into a
// right-justified, sign- or zero-extended 32-bit load value.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] fetched,
    input  logic [1:0]  size,
    input  logic        se,
    output logic [31:0] data
);

    logic fill_bit;

    // fetched[31:24] is the byte at the access address, so the sign bit of
    // both byte and halfword loads is always fetched[31].
    always_comb begin
        data     = 32'h0;
        fill_bit = se & fetched[31];
        case (size)
            SZ_BYTE: data = {{24{fill_bit}}, fetched[31:24]};
            SZ_HALF: data = {{16{fill_bit}}, fetched[31:16]};
            SZ_WORD: data = fetched;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable big-endian data memory, combinational read, write on the
// rising clock. Define DMEM_RESET_CLEAR_EN to clear contents on reset.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = DMEM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] A,
    input  logic [31:0]   DI,
    input  logic [1:0]    Size,
    input  logic          R_W,
    input  logic          E,
    input  logic          SE,
    output logic [31:0]   DO
);

    logic [7:0]    mem [0:DEPTH-1];

    logic [AW-1:0] addr      [4];
    logic [7:0]    wr_byte   [4];
    logic [3:0]    byte_we;
    logic [31:0]   fetched;
    logic [31:0]   aligned;
    logic          size_ok;
    logic          rd_en;
    logic          wr_en;
    int unsigned   nbytes;

    // Address arithmetic is AW bits wide, so A+k wraps modulo DEPTH for free.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            addr[k] = A + AW'(k);
        end
        fetched = {mem[addr[0]], mem[addr[1]], mem[addr[2]], mem[addr[3]]};
    end

    always_comb begin
        nbytes  = size_bytes(Size);
        size_ok = (nbytes != 0);
        rd_en   = reset & E & ~R_W & size_ok;
        wr_en   = reset & E &  R_W & size_ok;
        byte_we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wr_byte[k] = 8'h00;
            if (k < nbytes) begin
                byte_we[k] = wr_en;
                // Lane k of an n-byte store takes DI byte (n-1-k), keeping DI right-justified.
                wr_byte[k] = DI[8*(nbytes-1-k) +: 8];
            end
        end
    end

    dmem_load_align u_align (
        .fetched (fetched),
        .size    (Size),
        .se      (SE),
        .data    (aligned)
    );

    assign DO = rd_en ? aligned : 32'h0;

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (byte_we[k]) begin
                    mem[addr[k]] <= wr_byte[k];
                end
            end
        end
    end
`else
    // Contents survive reset; byte_we already folds in reset so no edge
    // seen while reset is low can write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (byte_we[k]) begin
                mem[addr[k]] <= wr_byte[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected DO values and a
// negedge monitor pops and compares them while a check strobe is raised.
module tb_data_memory;
    import dmem_pkg::*;

    logic        clk;
    logic        reset;
    logic [8:0]  A;
    logic [31:0] DI;
    logic [1:0]  Size;
    logic        R_W;
    logic        E;
    logic        SE;
    logic [31:0] DO;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    logic rd_strobe;
    int   checks_total;
    int   checks_passed;
    int   timeout_fails;

    data_memory dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .DI    (DI),
        .Size  (Size),
        .R_W   (R_W),
        .E     (E),
        .SE    (SE),
        .DO    (DO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: DO is compared mid-cycle, away from the write edge.
    always @(negedge clk) begin
        exp_t item;
        if (rd_strobe) begin
            checks_total++;
            if (sb_q.size() == 0) begin
                $display("[TB] FAIL unexpected_strobe: DO=%h with no expected value queued", DO);
            end else begin
                item = sb_q.pop_front();
                if (DO === item.exp) begin
                    checks_passed++;
                end else begin
                    $display("[TB] FAIL %s: DO=%h expected=%h", item.name, DO, item.exp);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [8:0] a, input logic [31:0] di,
                                  input logic [1:0] size, input logic rw,
                                  input logic e, input logic se);
        A    = a;
        DI   = di;
        Size = size;
        R_W  = rw;
        E    = e;
        SE   = se;
    endtask

    task automatic check_output(input string name, input logic [31:0] exp);
        exp_t item;
        item.name = name;
        item.exp  = exp;
        sb_q.push_back(item);
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic write_op(input string name, input logic [8:0] a, input logic [31:0] di,
                            input logic [1:0] size, input logic e);
        apply_stimulus(a, di, size, 1'b1, e, 1'b0);
        check_output(name, 32'h0);
    endtask

    task automatic read_op(input string name, input logic [8:0] a, input logic [1:0] size,
                           input logic se, input logic [31:0] exp);
        apply_stimulus(a, 32'h0, size, 1'b0, 1'b1, se);
        check_output(name, exp);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        timeout_fails = 0;
        rd_strobe     = 1'b0;
        reset         = 1'b0;
        apply_stimulus(9'd0, 32'h0, SZ_BYTE, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        read_op("reset_do_zero", 9'd0, SZ_WORD, 1'b0, 32'h0);
        reset = 1'b1;

        write_op("do_zero_during_write", 9'd4, 32'hDEADBEEF, SZ_WORD, 1'b1);
        read_op("word_roundtrip",   9'd4, SZ_WORD, 1'b0, 32'hDEADBEEF);
        read_op("byte_msb_zext",    9'd4, SZ_BYTE, 1'b0, 32'h000000DE);
        read_op("byte_lsb_sext",    9'd7, SZ_BYTE, 1'b1, 32'hFFFFFFEF);
        read_op("half_unaligned",   9'd5, SZ_HALF, 1'b0, 32'h0000ADBE);
        read_op("word_se_ignored",  9'd4, SZ_WORD, 1'b1, 32'hDEADBEEF);

        write_op("byte_write_do", 9'd10, 32'hFFFFFF85, SZ_BYTE, 1'b1);
        read_op("byte_sext",  9'd10, SZ_BYTE, 1'b1, 32'hFFFFFF85);
        read_op("byte_zext",  9'd10, SZ_BYTE, 1'b0, 32'h00000085);

        write_op("half_write_do", 9'd20, 32'h00008001, SZ_HALF, 1'b1);
        read_op("half_sext",  9'd20, SZ_HALF, 1'b1, 32'hFFFF8001);
        read_op("half_zext",  9'd20, SZ_HALF, 1'b0, 32'h00008001);
        read_op("half_lo_byte", 9'd21, SZ_BYTE, 1'b0, 32'h00000001);

        write_op("wrap_write_do", 9'd510, 32'h11223344, SZ_WORD, 1'b1);
        read_op("wrap_b510",  9'd510, SZ_BYTE, 1'b0, 32'h00000011);
        read_op("wrap_b511",  9'd511, SZ_BYTE, 1'b0, 32'h00000022);
        read_op("wrap_half0", 9'd0,   SZ_HALF, 1'b0, 32'h00003344);
        read_op("wrap_word",  9'd510, SZ_WORD, 1'b0, 32'h11223344);
        read_op("wrap_half511", 9'd511, SZ_HALF, 1'b1, 32'h00002233);

        write_op("e0_write_do", 9'd4, 32'h00000000, SZ_WORD, 1'b0);
        read_op("e0_no_write", 9'd4, SZ_WORD, 1'b0, 32'hDEADBEEF);
        write_op("size11_write_do", 9'd4, 32'h00000000, 2'b11, 1'b1);
        read_op("size11_no_write", 9'd4, SZ_WORD, 1'b0, 32'hDEADBEEF);
        read_op("size11_read_zero", 9'd4, 2'b11, 1'b0, 32'h0);
        apply_stimulus(9'd4, 32'h0, SZ_WORD, 1'b0, 1'b0, 1'b0);
        check_output("e0_read_zero", 32'h0);

        // Read set up, then reset dropped mid-cycle: DO must collapse at once.
        apply_stimulus(9'd4, 32'h0, SZ_WORD, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        check_output("reset_midread_zero", 32'h0);

        // A word write is pending across an edge that sees reset low.
        apply_stimulus(9'd4, 32'hCAFEF00D, SZ_WORD, 1'b1, 1'b1, 1'b0);
        check_output("reset_write_do", 32'h0);
        apply_stimulus(9'd4, 32'h0, SZ_WORD, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifdef DMEM_RESET_CLEAR_EN
        read_op("post_reset_word4",  9'd4,   SZ_WORD, 1'b0, 32'h0);
        read_op("post_reset_byte10", 9'd10,  SZ_BYTE, 1'b0, 32'h0);
        read_op("post_reset_wrap",   9'd510, SZ_WORD, 1'b0, 32'h0);
`else
        read_op("post_reset_word4",  9'd4,   SZ_WORD, 1'b0, 32'hDEADBEEF);
        read_op("post_reset_byte10", 9'd10,  SZ_BYTE, 1'b0, 32'h00000085);
        read_op("post_reset_wrap",   9'd510, SZ_WORD, 1'b0, 32'h11223344);
`endif

        write_op("post_reset_write_do", 9'd8, 32'h01020304, SZ_WORD, 1'b1);
        read_op("post_reset_write", 9'd8, SZ_WORD, 1'b0, 32'h01020304);

        apply_stimulus(9'd0, 32'h0, SZ_BYTE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
            timeout_fails++;
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total + timeout_fails);
        $finish;
    end

endmodule
